// File: rtl/zigbee_ctrl_pkg.sv
// Shared types for the ZigBee select sequencer: sequencer states and the
// packed select configuration word.
package zigbee_ctrl_pkg;

  localparam int CFG_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DWELL  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // SEL17 sits in the LSB so it changes fastest as the index increments.
  typedef struct packed {
    logic [2:0] sel1;
    logic [2:0] sel2;
    logic [1:0] sel15;
    logic [1:0] sel6;
    logic [1:0] sel9;
    logic       sel11;
    logic       sel12;
    logic       sel3;
    logic       sel17;
  } cfg_t;

  function automatic cfg_t cfg_succ(input cfg_t c);
    return cfg_t'(CFG_W'(c) + 16'd1);
  endfunction

endpackage

// File: rtl/zigbee_phase_counter.sv
// Loadable down-counter with enable and zero flag; times both the settle
// and the dwell phase of the sequencer.
module zigbee_phase_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count;

  // Count register: load wins over decrement; stops at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end else begin
      count <= count;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/zigbee_sel_sequencer.sv
// Start/done handshaked controller that steps the TOP select lines through a
// range of packed configurations with a flush phase and a dwell phase each.
module zigbee_sel_sequencer
  import zigbee_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int DWELL_W       = 16
) (
  input  logic               inClock,
  input  logic               inReset,
  input  logic               inStart,
  input  logic               inAbort,
  input  logic               inPause,
  input  logic [DWELL_W-1:0] inDwell,
  input  logic [CFG_W-1:0]   inFirstCfg,
  input  logic [CFG_W-1:0]   inLastCfg,
  output logic [2:0]         outSEL1,
  output logic [2:0]         outSEL2,
  output logic [1:0]         outSEL15,
  output logic [1:0]         outSEL6,
  output logic [1:0]         outSEL9,
  output logic               outSEL11,
  output logic               outSEL12,
  output logic               outSEL3,
  output logic               outSEL17,
  output logic               outReadEnable,
  output logic               outCfgValid,
  output logic               outBusy,
  output logic               outDone,
  output logic [CFG_W-1:0]   outCfgIndex
);

  localparam logic [DWELL_W-1:0] SETTLE_LOAD = DWELL_W'(SETTLE_CYCLES - 1);

  state_t             state, state_nxt;
  cfg_t               cfg, cfg_nxt;
  logic [CFG_W-1:0]   last_cfg, last_nxt;
  logic [DWELL_W-1:0] dwell, dwell_nxt;
  logic               cnt_load, cnt_en, cnt_zero, hold;
  logic [DWELL_W-1:0] cnt_value;
  logic               re_nxt, valid_nxt, busy_nxt, done_nxt;
  logic               re_q, valid_q, busy_q, done_q;

  zigbee_phase_counter #(.W(DWELL_W)) u_phase (
    .clk        (inClock),
    .rst        (inReset),
    .en         (cnt_en),
    .load       (cnt_load),
    .load_value (cnt_value),
    .zero       (cnt_zero)
  );

  // Next-state, phase-counter control and next registered outputs.
  always_comb begin
    state_nxt = state;
    cfg_nxt   = cfg;
    last_nxt  = last_cfg;
    dwell_nxt = dwell;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    cnt_value = SETTLE_LOAD;
    hold      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (inStart && !inAbort) begin
          state_nxt = ST_SETTLE;
          cfg_nxt   = cfg_t'(inFirstCfg);
          last_nxt  = inLastCfg;
          dwell_nxt = (inDwell == '0) ? DWELL_W'(1) : inDwell;
          cnt_load  = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (inAbort) begin
          state_nxt = ST_IDLE;
        end else if (inPause) begin
          hold = 1'b1;
        end else if (cnt_zero) begin
          state_nxt = ST_DWELL;
          cnt_load  = 1'b1;
          cnt_value = dwell - DWELL_W'(1);
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DWELL: begin
        if (inAbort) begin
          state_nxt = ST_IDLE;
        end else if (inPause) begin
          hold = 1'b1;
        end else if (cnt_zero) begin
          if (CFG_W'(cfg) == last_cfg) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_SETTLE;
            cfg_nxt   = cfg_succ(cfg);
            cnt_load  = 1'b1;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    // Flush read enable is suppressed while the sequencer is frozen.
    busy_nxt  = (state_nxt == ST_SETTLE) || (state_nxt == ST_DWELL);
    re_nxt    = (state_nxt == ST_SETTLE) && !hold;
    valid_nxt = (state_nxt == ST_DWELL);
    done_nxt  = (state_nxt == ST_DONE);
  end

  // State, latched sweep parameters and registered outputs.
  always_ff @(posedge inClock) begin
    if (inReset) begin
      state    <= ST_IDLE;
      cfg      <= cfg_t'(16'h0000);
      last_cfg <= 16'h0000;
      dwell    <= '0;
      re_q     <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cfg      <= cfg_nxt;
      last_cfg <= last_nxt;
      dwell    <= dwell_nxt;
      re_q     <= re_nxt;
      valid_q  <= valid_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
    end
  end

  assign outSEL1       = cfg.sel1;
  assign outSEL2       = cfg.sel2;
  assign outSEL15      = cfg.sel15;
  assign outSEL6       = cfg.sel6;
  assign outSEL9       = cfg.sel9;
  assign outSEL11      = cfg.sel11;
  assign outSEL12      = cfg.sel12;
  assign outSEL3       = cfg.sel3;
  assign outSEL17      = cfg.sel17;
  assign outCfgIndex   = CFG_W'(cfg);
  assign outReadEnable = re_q;
  assign outCfgValid   = valid_q;
  assign outBusy       = busy_q;
  assign outDone       = done_q;

endmodule

// File: tb/tb_zigbee_sel_sequencer.sv
// Scoreboard bench for zigbee_sel_sequencer: sweeps are described by a
// high-level model (index list, cycle totals) and checked by a monitor.
module tb_zigbee_sel_sequencer;

  localparam int S = 4;

  logic        inClock = 1'b0;
  logic        inReset = 1'b1, inStart = 1'b0, inAbort = 1'b0, inPause = 1'b0;
  logic [15:0] inDwell = 16'd0, inFirstCfg = 16'd0, inLastCfg = 16'd0;
  logic [2:0]  outSEL1, outSEL2;
  logic [1:0]  outSEL15, outSEL6, outSEL9;
  logic        outSEL11, outSEL12, outSEL3, outSEL17;
  logic        outReadEnable, outCfgValid, outBusy, outDone;
  logic [15:0] outCfgIndex;

  int n_checks = 0;
  int n_fail   = 0;

  // kind: 0 completes, 1 aborted, 2 reset
  typedef struct {
    logic [15:0] first;
    logic [15:0] last;
    int busy; int re; int valid; int seen; int n; int kind;
  } sweep_t;

  sweep_t      sweep_q[$];
  logic [15:0] cfg_q[$];

  zigbee_sel_sequencer #(.SETTLE_CYCLES(S), .DWELL_W(16)) dut (
    .inClock(inClock), .inReset(inReset), .inStart(inStart), .inAbort(inAbort),
    .inPause(inPause), .inDwell(inDwell), .inFirstCfg(inFirstCfg), .inLastCfg(inLastCfg),
    .outSEL1(outSEL1), .outSEL2(outSEL2), .outSEL15(outSEL15), .outSEL6(outSEL6),
    .outSEL9(outSEL9), .outSEL11(outSEL11), .outSEL12(outSEL12), .outSEL3(outSEL3),
    .outSEL17(outSEL17), .outReadEnable(outReadEnable), .outCfgValid(outCfgValid),
    .outBusy(outBusy), .outDone(outDone), .outCfgIndex(outCfgIndex)
  );

  always #5 inClock = ~inClock;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_sels(input logic [15:0] idx);
    chk("cfg_index", outCfgIndex, idx);
    chk("sel1",  outSEL1,  idx[15:13]);
    chk("sel2",  outSEL2,  idx[12:10]);
    chk("sel15", outSEL15, idx[9:8]);
    chk("sel6",  outSEL6,  idx[7:6]);
    chk("sel9",  outSEL9,  idx[5:4]);
    chk("sel11", outSEL11, idx[3]);
    chk("sel12", outSEL12, idx[2]);
    chk("sel3",  outSEL3,  idx[1]);
    chk("sel17", outSEL17, idx[0]);
  endtask

  // Monitor: counts per-sweep activity and compares against the scoreboard.
  logic   prev_busy = 1'b0, prev_valid = 1'b0, in_sweep = 1'b0;
  int     bcnt, rcnt, vcnt, seen, popped;
  sweep_t cur;

  always @(negedge inClock) begin
    if (outBusy && !prev_busy) begin
      bcnt = 0; rcnt = 0; vcnt = 0; seen = 0; popped = 0;
      if (sweep_q.size() == 0) begin
        in_sweep = 1'b0;
        chk("unexpected_start", outBusy, 0);
      end else begin
        in_sweep = 1'b1;
        chk("first_cfg", outCfgIndex, sweep_q[0].first);
      end
    end
    if (outBusy) begin
      bcnt++;
      rcnt += int'(outReadEnable);
      vcnt += int'(outCfgValid);
      if (outCfgValid && !prev_valid) begin
        seen++;
        if (in_sweep && popped < sweep_q[0].n && cfg_q.size() > 0) begin
          popped++;
          check_sels(cfg_q.pop_front());
        end
      end
    end
    if (prev_busy && !outBusy) begin
      if (in_sweep) begin
        cur = sweep_q.pop_front();
        in_sweep = 1'b0;
        chk("done_pulse", outDone, (cur.kind == 0) ? 1 : 0);
        chk("busy_cycles", bcnt, cur.busy);
        chk("cfgs_seen", seen, cur.seen);
        if (cur.kind == 0) begin
          chk("re_cycles", rcnt, cur.re);
          chk("valid_cycles", vcnt, cur.valid);
          check_sels(cur.last);
        end else begin
          chk("end_valid", outCfgValid, 0);
          chk("end_re", outReadEnable, 0);
          if (cur.kind == 2) check_sels(16'h0000);
        end
        while (popped < cur.n && cfg_q.size() > 0) begin
          void'(cfg_q.pop_front());
          popped++;
        end
      end
    end else begin
      chk("no_spurious_done", outDone, 0);
    end
    prev_busy  = outBusy;
    prev_valid = outCfgValid;
  end

  // pmode: 0 none, 1 random, 2 seven cycles mid-dwell, 3 three cycles in settle
  task automatic run_sweep(input logic [15:0] first, input logic [15:0] last,
                           input logic [15:0] dwell, input int pmode,
                           input int kind, input int k_in);
    logic [15:0] diff;
    bit          pq[$];
    sweep_t      r;
    int n, d, p, total, active, pauses, pd, blk, k;
    bit pb;
    diff = last - first;
    n = int'(diff) + 1;
    d = (dwell == 16'd0) ? 1 : int'(dwell);
    p = S + d;
    total = p * n;
    active = 0; pauses = 0; pd = 0; blk = 0;
    while (kind == 0 && active < total) begin
      pb = 1'b0;
      if (pmode == 1) pb = ($urandom_range(0, 3) == 0);
      if (pmode == 2 && active == S + 3 && blk < 7) begin pb = 1'b1; blk++; end
      if (pmode == 3 && active == 1 && blk < 3) begin pb = 1'b1; blk++; end
      pq.push_back(pb);
      if (pb) begin
        pauses++;
        if ((active % p) >= S) pd++;
      end else begin
        active++;
      end
    end
    k = (k_in == 0) ? int'($urandom_range(1, total)) : k_in;
    r.first = first; r.last = last; r.n = n; r.kind = kind;
    r.re = S * n; r.valid = d * n + pd;
    if (kind == 0) begin
      r.busy = total + pauses;
      r.seen = n;
    end else begin
      r.busy = k;
      r.seen = 0;
      for (int j = 0; j < n; j++) if (j * p + S < k) r.seen++;
    end
    for (int i = 0; i < n; i++) cfg_q.push_back(first + 16'(i));
    sweep_q.push_back(r);

    inFirstCfg = first; inLastCfg = last; inDwell = dwell; inStart = 1'b1;
    @(posedge inClock); #1;
    if (kind == 0) begin
      foreach (pq[i]) begin
        inPause = pq[i];
        inStart = 1'($urandom_range(0, 1));
        inFirstCfg = 16'($urandom); inLastCfg = 16'($urandom); inDwell = 16'($urandom);
        @(posedge inClock); #1;
      end
    end else begin
      for (int i = 1; i <= k; i++) begin
        inStart = 1'($urandom_range(0, 1));
        inFirstCfg = 16'($urandom); inLastCfg = 16'($urandom); inDwell = 16'($urandom);
        if (i == k) begin
          if (kind == 1) inAbort = 1'b1;
          else inReset = 1'b1;
        end
        @(posedge inClock); #1;
      end
    end
    inPause = 1'b0; inStart = 1'b0; inAbort = 1'b0; inReset = 1'b0;
    repeat ($urandom_range(2, 4)) begin @(posedge inClock); #1; end
  endtask

  initial begin
    repeat (3) @(posedge inClock);
    @(negedge inClock);
    check_sels(16'h0000);
    chk("rst_re", outReadEnable, 0);
    chk("rst_valid", outCfgValid, 0);
    chk("rst_busy", outBusy, 0);
    chk("rst_done", outDone, 0);
    @(posedge inClock); #1;
    inReset = 1'b0;
    @(posedge inClock); #1;

    run_sweep(16'h0000, 16'h0002, 16'd10, 0, 0, 0);
    run_sweep(16'hFFFE, 16'h0001, 16'd1, 0, 0, 0);
    run_sweep(16'h1234, 16'h1234, 16'd0, 0, 0, 0);
    run_sweep(16'h0040, 16'h0040, 16'd10, 2, 0, 0);
    run_sweep(16'h0100, 16'h0101, 16'd3, 3, 0, 0);
    run_sweep(16'h0005, 16'h0007, 16'd4, 0, 1, S + 2);

    inStart = 1'b1; inAbort = 1'b1; inFirstCfg = 16'h0777; inLastCfg = 16'h0777;
    @(posedge inClock); #1;
    inStart = 1'b0; inAbort = 1'b0;
    @(negedge inClock);
    chk("start_abort_idle", outBusy, 0);
    @(posedge inClock); #1;

    run_sweep(16'hA000, 16'hA002, 16'd5, 0, 2, S + 3);
    run_sweep(16'h0010, 16'h0011, 16'd2, 0, 0, 0);

    for (int t = 0; t < 30; t++) begin
      logic [15:0] f;
      int kd, kind;
      f = 16'($urandom);
      kd = int'($urandom_range(0, 9));
      kind = (kd < 7) ? 0 : ((kd < 9) ? 1 : 2);
      run_sweep(f, f + 16'($urandom_range(0, 3)), 16'($urandom_range(0, 6)), 1, kind, 0);
    end

    repeat (4) @(posedge inClock);
    #1;
    chk("scoreboard_empty", sweep_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    repeat (50000) @(posedge inClock);
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
